// File: rtl/tour_cmd_seq.sv
// Knight-tour command sequencer: replays one-hot solver moves as Y/X move command pairs.
// Optional handshake watchdog is enabled with the TOUR_CMD_WDOG_EN macro.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES = 24,
  parameter int unsigned IDX_W     = 5,
  parameter logic [7:0]  DONE_RESP = 8'hA5,
  parameter logic [7:0]  BUSY_RESP = 8'h5A,
  parameter logic [7:0]  ERR_RESP  = 8'hEE,
  parameter int unsigned WDOG_CYC  = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic             abort_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             tour_err
);

  if (NUM_MOVES < 1 || (2 ** IDX_W) < NUM_MOVES || WDOG_CYC < 2) begin : g_bad_param
    $error("tour_cmd_seq: illegal parameter combination");
  end

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_MOVES - 1);

  typedef enum logic [2:0] {StIdle, StYMove, StYHold, StXMove, StXHold} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             wdog_trip;

  // Move decode: bit0 N2W1, bit1 N2E1, bit2 W2N1, bit3 W2S1,
  //              bit4 S2W1, bit5 S2E1, bit6 E2S1, bit7 E2N1.
  logic        y_south, y_two, x_east, x_two, move_legal, last_move;
  logic [15:0] cmd_y, cmd_x, cmd_tour;
  logic        cmd_rdy_tour;

  assign y_south    = |(move & 8'b0111_1000);
  assign y_two      = |(move & 8'b0011_0011);
  assign x_east     = |(move & 8'b1110_0010);
  assign x_two      = |(move & 8'b1100_1100);
  assign move_legal = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
  assign cmd_y      = {4'h2, (y_south ? 8'h7F : 8'h00), (y_two ? 4'd2 : 4'd1)};
  assign cmd_x      = {4'h3, (x_east ? 8'hBF : 8'h3F), (x_two ? 4'd2 : 4'd1)};
  assign last_move  = (idx_q == LastIdx);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = err_q;
    done_d       = 1'b0;
    cmd_tour     = cmd_y;
    cmd_rdy_tour = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_tour) begin
          state_d = StYMove;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      StYMove: begin
        if (!move_legal) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cmd_rdy_tour = 1'b1;
          if (clr_cmd_rdy) state_d = StYHold;
        end
      end
      StYHold: begin
        if (send_resp) state_d = StXMove;
      end
      StXMove: begin
        cmd_tour     = cmd_x;
        cmd_rdy_tour = 1'b1;
        if (clr_cmd_rdy) state_d = StXHold;
      end
      StXHold: begin
        cmd_tour = cmd_x;
        if (send_resp) begin
          if (last_move) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StYMove;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wdog_trip) begin
      state_d = StIdle;
      idx_d   = idx_q;
      err_d   = 1'b1;
      done_d  = 1'b0;
    end

    // Abort overrides everything; progress index stays readable.
    if (abort_tour) begin
      state_d = StIdle;
      idx_d   = idx_q;
      err_d   = err_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef TOUR_CMD_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYC + 1);
  logic [WdogW-1:0] wdog_q;

  assign wdog_trip = (state_q != StIdle) && (wdog_q == WdogW'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q)) begin
      wdog_q <= '0;
    end else if (state_q != StIdle) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  assign tour_busy = (state_q != StIdle);
  assign mv_indx   = idx_q;
  assign tour_done = done_q;
  assign tour_err  = err_q;
  assign cmd       = tour_busy ? cmd_tour : cmd_UART;
  assign cmd_rdy   = tour_busy ? cmd_rdy_tour : cmd_rdy_UART;

  always_comb begin
    resp = BUSY_RESP;
    if (tour_busy && last_move) begin
      resp = DONE_RESP;
    end else if (!tour_busy && err_q) begin
      resp = ERR_RESP;
    end
  end

endmodule
